mem_sp_streamer: RTL and testbench
==================================

// Module: mem_sp_streamer
// PURPOSE
//  Address/control sequencer that sits directly in front of mem_sp and turns a stored polynomial into a
//  valid/ready word stream for the downstream ROLLO-II encrypt datapath. It reads len words from base_addr
//  upward, absorbs mem_sp's 1-cycle read latency with a 2-entry output buffer, and sustains 1 word/cycle
//  whenever m_ready is held high.
// PARAMETERS
//  WIDTH  8   word width; must equal the WIDTH of the attached mem_sp
//  DEPTH  64  memory depth in words; AW = `CLOG2(DEPTH)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle request; sampled only while busy=0
//  base_addr  in   AW      first word address, latched on start
//  len        in   AW+1    number of words, latched on start; values >DEPTH are clamped to DEPTH
//  busy       out  1       high from the cycle after an accepted start until done
//  done       out  1       1-cycle pulse: operation finished
//  mem_en     out  1       to mem_sp en
//  mem_we     out  1       to mem_sp we
//  mem_addr   out  AW      to mem_sp addr
//  mem_di     out  WIDTH   to mem_sp di
//  mem_do     in   WIDTH   from mem_sp do; valid the cycle after a mem_en=1,mem_we=0 access
//  m_valid    out  1       output stream valid
//  m_data     out  WIDTH   output stream word
//  m_ready    in   1       downstream accept
// BEHAVIOUR
//  - Reset: busy=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_di=0, m_valid=0, m_data=0. Reset flushes the
//    buffer, clears all counters, and discards any in-flight read. A reset mid-operation produces no done pulse.
//  - FSM IDLE -> RUN -> DRAIN -> IDLE.
//    * IDLE, start=1, clamped len!=0: latch base_addr and len, go to RUN.
//    * IDLE, start=1, len==0: pulse done on the next cycle and stay in IDLE; busy never rises.
//    * RUN: issue a read (mem_en=1, mem_we=0, mem_addr=current address) in every cycle where
//      buffer occupancy + reads in flight + 0 < 2, after accounting for a pop in the same cycle.
//      When issued count reaches len, go to DRAIN.
//    * DRAIN: no issues. When the last word is popped (m_valid & m_ready), pulse done in the next cycle,
//      drop busy in that same cycle, and return to IDLE.
//  - Address sequence is base_addr+i with wrap DEPTH-1 -> 0. The wrap is an explicit compare, so it holds
//    for non-power-of-2 DEPTH.
//  - Buffer: 2-entry FIFO, written with mem_do one cycle after each issue. m_data is the FIFO head; m_valid
//    is high when the FIFO is not empty. m_data/m_valid are stable while m_valid=1 and m_ready=0.
//    A simultaneous push and pop keeps occupancy unchanged. The FIFO never overflows, because the issue rule
//    guarantees space.
//  - Latency: start to first m_valid is 3 cycles (latch, issue, capture). With m_ready=1 the throughput is
//    1 word/cycle and done arrives len+3 cycles after start.
//  - start while busy=1 is ignored. mem_en=0 in every cycle where no access is issued.
// CONFIGURATION
//  MEM_STREAM_WR_EN defined: adds the following ports.
//    mode     in   1      0 = read, 1 = write; latched on start
//    s_valid  in   1      input stream valid
//    s_data   in   WIDTH  input stream word
//    s_ready  out  1      input stream ready; reset 0
//   In write mode, RUN holds s_ready=1. Each s_valid & s_ready cycle drives mem_en=1, mem_we=1,
//   mem_di=s_data and advances the address. After len writes the FSM skips DRAIN and pulses done on the
//   next cycle. Read mode is unchanged.
//  MEM_STREAM_WR_EN undefined: those ports do not exist; mem_we and mem_di are tied to 0.
// STRUCTURE
//  - Shared include define.v: `CLOG2 macro and the FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1,
//    ST_DRAIN=2'd2.
//  - One sub-module: stream_fifo2, a parameterised WIDTH x 2 FIFO with push/pop/count. It is reused by
//    other stream stages.
//  - mem_sp is instantiated by the parent, not inside this block.
// TESTING  (bench pairs this block with a mem_sp preloaded via FILE; mem[i]=i+1)
//  1. base=0, len=4, m_ready=1 -> m_data 1,2,3,4 on consecutive cycles; done 7 cycles after start.
//  2. DEPTH=64, base=62, len=4 -> addresses 62,63,0,1; data 63,64,1,2.
//  3. base=0, len=8, m_ready toggling 1,0,0,1,... -> no word lost or duplicated; data held while stalled;
//     occupancy never exceeds 2.
//  4. start with len=0 -> done 1 cycle later, busy stays 0, mem_en never asserted. len=100 -> exactly 64 words.
//  5. rst asserted mid-stream (after word 3 of 8) -> next cycle all outputs 0 and no done. A new start
//     (base=10, len=2) then returns 11,12.
//  6. MEM_STREAM_WR_EN: write 0xA5,0x5A to base=5, then read back base=5, len=2 -> stream A5,5A;
//     done after each operation.

Source files
------------

// File: rtl/mem_sp_streamer_pkg.sv
// Shared types for the mem_sp stream sequencer: FSM state encoding and
// the output buffer depth the issue rule is sized against.
package mem_sp_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry stream FIFO with push/pop and occupancy count.
// The head word is presented combinationally on data_o; storage clears on reset.
module stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q == 1'(gi))) begin
          mem_q[gi] <= data_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ do_push;
      rd_ptr_q <= rd_ptr_q ^ do_pop;
      count_q  <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_sp_streamer.sv
// Address/control sequencer streaming len words out of mem_sp from base_addr upward.
// Optional write-stream mode is enabled by defining MEM_STREAM_WR_EN.
module mem_sp_streamer
  import mem_sp_streamer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_di,
  input  logic [WIDTH-1:0] mem_do,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef MEM_STREAM_WR_EN
  ,
  input  logic             mode,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready
`endif
);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     iss_left_q, iss_left_d;
  logic [AW:0]     pop_left_q, pop_left_d;
  logic            inflight_q, inflight_d;
  logic            done_q, done_d;
  logic            wr_mode_q, wr_mode_d;

  logic [AW:0]     len_c;
  logic [AW-1:0]   addr_inc;
  logic [1:0]      fifo_count;
  logic [2:0]      occ;
  logic            pop;
  logic            issue_rd;
  logic            issue_wr;
  logic            issue;

  assign len_c    = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign addr_inc = (addr_q == AW'(DEPTH-1)) ? '0 : addr_q + 1'b1;
  assign pop      = m_valid && m_ready;
  assign occ      = {1'b0, fifo_count} + {2'b0, inflight_q};
  // Reads in flight count against buffer space, so a read may only issue if its word is guaranteed a slot.
  assign issue_rd = (state_q == ST_RUN) && !wr_mode_q && (occ < (3'(FIFO_DEPTH) + {2'b0, pop}));
`ifdef MEM_STREAM_WR_EN
  assign issue_wr = (state_q == ST_RUN) && wr_mode_q && s_valid;
`else
  assign issue_wr = 1'b0;
`endif
  assign issue    = issue_rd || issue_wr;

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  (mem_do),
    .pop_i   (pop),
    .data_o  (m_data),
    .valid_o (m_valid),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      iss_left_q <= '0;
      pop_left_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_mode_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_left_q <= iss_left_d;
      pop_left_q <= pop_left_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      wr_mode_q  <= wr_mode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_left_d = iss_left_q;
    pop_left_d = pop_left_q;
    inflight_d = issue_rd;
    done_d     = 1'b0;
    wr_mode_d  = wr_mode_q;
    if (issue) begin
      addr_d     = addr_inc;
      iss_left_d = iss_left_q - 1'b1;
    end
    if (pop) begin
      pop_left_d = pop_left_q - 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            addr_d     = base_addr;
            iss_left_d = len_c;
            pop_left_d = len_c;
`ifdef MEM_STREAM_WR_EN
            wr_mode_d  = mode;
`else
            wr_mode_d  = 1'b0;
`endif
          end
        end
      end
      ST_RUN: begin
        if (issue && (iss_left_q == (AW+1)'(1))) begin
          if (wr_mode_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (pop_left_q == (AW+1)'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    mem_en   = issue;
    mem_we   = issue_wr;
    mem_addr = addr_q;
    mem_di   = '0;
`ifdef MEM_STREAM_WR_EN
    s_ready  = (state_q == ST_RUN) && wr_mode_q;
    if (issue_wr) begin
      mem_di = s_data;
    end
`endif
  end

endmodule

// File: tb/tb_mem_sp_streamer.sv
// Directed bench for mem_sp_streamer with a behavioural mem_sp model (mem[i]=i+1).
// Vector table covers the main read cases; reset mid-stream and write mode are hand sequences.
module tb_mem_sp_streamer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      len;
  logic             busy, done, mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_di;
  logic [WIDTH-1:0] mem_do;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
`ifdef MEM_STREAM_WR_EN
  logic             mode;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
`endif

  mem_sp_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_di    (mem_di),
    .mem_do    (mem_do),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
`ifdef MEM_STREAM_WR_EN
    ,
    .mode      (mode),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 1);
    mem_do = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_di;
      else        mem_do <= mem[mem_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] got_q [$];
  int   done_lat;
  logic busy_seen, men_seen, hold_bad, busy_at_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic ready_of(input int pat, input int t);
    return (pat == 0) ? 1'b1 : ((t % 3) == 0);
  endfunction

  // Issues one start and observes every cycle until done (bounded).
  task automatic run_op(input int b, input int l, input int pat);
    logic pv, pr;
    logic [WIDTH-1:0] pd;
    got_q.delete();
    busy_seen = 0; men_seen = 0; hold_bad = 0; busy_at_done = 0; done_lat = -1;
    pv = 0; pr = 0; pd = '0;
`ifdef MEM_STREAM_WR_EN
    mode = 1'b0; s_valid = 1'b0; s_data = '0;
`endif
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l); m_ready = ready_of(pat, 0);
    for (int t = 0; t < 400; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        start = 1'b0; m_ready = ready_of(pat, t);
      end
      @(negedge clk);
      if (busy) busy_seen = 1;
      if (mem_en) men_seen = 1;
      if (pv && !pr && (!m_valid || m_data !== pd)) hold_bad = 1;
      if (m_valid && m_ready) got_q.push_back(m_data);
      pv = m_valid; pr = m_ready; pd = m_data;
      if (done) begin
        done_lat = t;
        busy_at_done = busy;
        break;
      end
    end
    $display("op base=%0d len=%0d pat=%0d words=%0d done_lat=%0d", b, l, pat, got_q.size(), done_lat);
  endtask

  typedef struct {
    int base;
    int len;
    int pat;
    int exp_lat;   // -1: latency not fixed by the ready pattern
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int exp_n;

    vecs[0] = '{base: 0,  len: 4,   pat: 0, exp_lat: 7};
    vecs[1] = '{base: 62, len: 4,   pat: 0, exp_lat: 7};
    vecs[2] = '{base: 0,  len: 8,   pat: 1, exp_lat: -1};
    vecs[3] = '{base: 3,  len: 0,   pat: 0, exp_lat: 1};
    vecs[4] = '{base: 0,  len: 100, pat: 0, exp_lat: 67};

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
`ifdef MEM_STREAM_WR_EN
    mode = 1'b0; s_valid = 1'b0; s_data = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    int'(busy),     0);
    chk("rst_done",    int'(done),     0);
    chk("rst_mem_en",  int'(mem_en),   0);
    chk("rst_mem_we",  int'(mem_we),   0);
    chk("rst_addr",    int'(mem_addr), 0);
    chk("rst_di",      int'(mem_di),   0);
    chk("rst_m_valid", int'(m_valid),  0);
    chk("rst_m_data",  int'(m_data),   0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      run_op(vecs[k].base, vecs[k].len, vecs[k].pat);
      exp_n = (vecs[k].len > DEPTH) ? DEPTH : vecs[k].len;
      if (vecs[k].exp_lat >= 0) chk($sformatf("v%0d_done_lat", k), done_lat, vecs[k].exp_lat);
      else                      chk($sformatf("v%0d_done_seen", k), int'(done_lat > 0), 1);
      chk($sformatf("v%0d_count", k), got_q.size(), exp_n);
      for (int i = 0; i < got_q.size() && i < exp_n; i++)
        chk($sformatf("v%0d_data%0d", k, i), int'(got_q[i]), ((vecs[k].base + i) % DEPTH) + 1);
      chk($sformatf("v%0d_busy_seen", k), int'(busy_seen), int'(exp_n != 0));
      chk($sformatf("v%0d_mem_en_seen", k), int'(men_seen), int'(exp_n != 0));
      chk($sformatf("v%0d_hold", k), int'(hold_bad), 0);
      chk($sformatf("v%0d_busy_at_done", k), int'(busy_at_done), 0);
    end

    // Reset in the middle of an 8-word read, after the third word.
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; len = 7'd8; m_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 30 && n < 3; t++) begin
      if (t > 0) begin @(posedge clk); #1; start = 1'b0; end
      @(negedge clk);
      if (m_valid && m_ready) n++;
    end
    chk("mid_words_before_rst", n, 3);
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",    int'(busy),     0);
    chk("mid_rst_done",    int'(done),     0);
    chk("mid_rst_mem_en",  int'(mem_en),   0);
    chk("mid_rst_addr",    int'(mem_addr), 0);
    chk("mid_rst_m_valid", int'(m_valid),  0);
    chk("mid_rst_m_data",  int'(m_data),   0);
    n = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (done || m_valid || busy || mem_en) n++;
    end
    chk("mid_rst_quiet", n, 0);
    $display("op reset mid-stream after 3 words");
    run_op(10, 2, 0);
    chk("post_rst_done_lat", done_lat, 5);
    chk("post_rst_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("post_rst_data0", int'(got_q[0]), 11);
      chk("post_rst_data1", int'(got_q[1]), 12);
    end

`ifdef MEM_STREAM_WR_EN
    begin
      logic [WIDTH-1:0] wd [2];
      int idx;
      int wlat;
      wd[0] = 8'hA5; wd[1] = 8'h5A;
      idx = 0; wlat = -1;
      @(posedge clk); #1;
      start = 1'b1; mode = 1'b1; base_addr = 6'd5; len = 7'd2; s_valid = 1'b0; m_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
        if (t > 0) begin
          @(posedge clk); #1;
          start = 1'b0;
          s_valid = (idx < 2);
          s_data  = (idx < 2) ? wd[idx] : '0;
        end
        @(negedge clk);
        if (s_valid && s_ready) idx++;
        if (done) begin wlat = t; break; end
      end
      s_valid = 1'b0;
      $display("op write base=5 len=2 written=%0d done_lat=%0d", idx, wlat);
      chk("wr_count", idx, 2);
      chk("wr_done_lat", wlat, 3);
      run_op(5, 2, 0);
      chk("rb_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
        chk("rb_data0", int'(got_q[0]), 'hA5);
        chk("rb_data1", int'(got_q[1]), 'h5A);
      end
      chk("rb_done_lat", done_lat, 5);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
